snoopy_game_fsm: RTL and testbench

- Top-level game-flow controller, directly downstream of the collision/screen-end detector.
- Consumes the detector's `collided` and `reached_screen_end` flags and drives round restarts, mover enable, lives, level, score and the win/lose screens.
- Also generates the active-low synchronous clear pulse that re-arms the detector and the mover at the start of each round.

---
 rtl/snoopy_pkg.sv | 18 +
 rtl/snoopy_game_fsm_pause_timer.sv | 24 ++
 rtl/snoopy_game_fsm.sv | 115 +++++++++++
 tb/tb_snoopy_game_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/snoopy_pkg.sv
// Shared definitions for the Snoopy game slice: FSM state codes and screen/colour constants.
package snoopy_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    PLAY     = 3'd2,
    HIT      = 3'd3,
    LEVEL_UP = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  localparam int unsigned SCREEN_W        = 160;
  localparam int unsigned SCREEN_H        = 120;
  localparam logic [2:0]  OBSTACLE_COLOUR = 3'b010;

endpackage

// File: rtl/snoopy_game_fsm_pause_timer.sv
// 6-bit frame-tick counter; done fires on the tick that makes the count reach PAUSE_FRAMES.
module pause_timer #(
  parameter int unsigned PAUSE_FRAMES = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic done
);
  import snoopy_pkg::*;

  logic [5:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (tick)  count <= count + 6'd1;
  end

  // Independent of clear so the FSM can derive clear from its next state without a loop.
  assign done = tick && (count == 6'(PAUSE_FRAMES - 1));

endmodule

// File: rtl/snoopy_game_fsm.sv
// Snoopy game-flow controller: rounds, lives, levels, score and win/lose screens.
// Optional feature macro: SNOOPY_BONUS_LIFE_EN (bonus life on each non-final level clear).
module snoopy_game_fsm #(
  parameter int unsigned NUM_LEVELS   = 4,
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned MAX_LIVES    = 3,
  parameter int unsigned PAUSE_FRAMES = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       collided,
  input  logic       reached_screen_end,
  input  logic       clear_done,
  output logic       round_resetn,
  output logic       clear_req,
  output logic       run,
  output logic [2:0] level,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic [2:0] state,
  output logic       game_over,
  output logic       win
);
  import snoopy_pkg::*;

`ifdef SNOOPY_BONUS_LIFE_EN
  localparam bit BONUS_EN = 1'b1;
`else
  localparam bit BONUS_EN = 1'b0;
`endif

  state_t cur, nxt;
  logic   start_q, start_rise;
  logic   final_clear;
  logic   pause_clear, pause_done;

  assign start_rise = start && !start_q;
  assign state      = cur;

  pause_timer #(.PAUSE_FRAMES(PAUSE_FRAMES)) u_pause (
    .clock (clock),
    .reset (reset),
    .clear (pause_clear),
    .tick  (frame_tick),
    .done  (pause_done)
  );

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:     if (start_rise) nxt = CLEAR;
      CLEAR:    if (clear_done) nxt = PLAY;
      PLAY: begin
        if (collided)                nxt = HIT;
        else if (reached_screen_end) nxt = LEVEL_UP;
      end
      HIT: begin
        if (lives == 2'd0)   nxt = LOSE;
        else if (pause_done) nxt = CLEAR;
      end
      LEVEL_UP: begin
        if (final_clear)     nxt = WIN;
        else if (pause_done) nxt = CLEAR;
      end
      WIN, LOSE: if (start_rise) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    pause_clear = (nxt != cur) || !(cur == HIT || cur == LEVEL_UP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur          <= IDLE;
      start_q      <= 1'b0;
      level        <= 3'd1;
      lives        <= 2'(START_LIVES);
      score        <= '0;
      final_clear  <= 1'b0;
      round_resetn <= 1'b0;
      clear_req    <= 1'b0;
      run          <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
    end else begin
      cur          <= nxt;
      start_q      <= start;
      // Outputs decode the next state so they are registered yet aligned with state.
      round_resetn <= !(nxt == IDLE || nxt == CLEAR);
      clear_req    <= (nxt == CLEAR);
      run          <= (nxt == PLAY);
      game_over    <= (nxt == LOSE);
      win          <= (nxt == WIN);

      if (cur == IDLE && nxt == CLEAR) begin
        level <= 3'd1;
        lives <= 2'(START_LIVES);
        score <= '0;
      end

      if (cur == PLAY && nxt == HIT) lives <= lives - 2'd1;

      if (cur == PLAY && nxt == LEVEL_UP) begin
        if (score != 8'hFF) score <= score + 8'd1;
        final_clear <= (level == 3'(NUM_LEVELS));
        if (level != 3'(NUM_LEVELS)) begin
          level <= level + 3'd1;
          if (BONUS_EN && (lives < 2'(MAX_LIVES))) lives <= lives + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snoopy_game_fsm.sv
// Self-checking bench for snoopy_game_fsm: directed game scenarios plus random play vs a behavioural model.
module tb_snoopy_game_fsm;

  localparam int NL = 4;
  localparam int SL = 3;
  localparam int ML = 3;
  localparam int PF = 30;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, frame_tick = 1'b0, collided = 1'b0, reached_screen_end = 1'b0, clear_done = 1'b0;
  logic       round_resetn, clear_req, run, game_over, win;
  logic [2:0] level, state;
  logic [1:0] lives;
  logic [7:0] score;

  int checks = 0;
  int failures = 0;

  snoopy_game_fsm #(.NUM_LEVELS(NL), .START_LIVES(SL), .MAX_LIVES(ML), .PAUSE_FRAMES(PF)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
    .collided(collided), .reached_screen_end(reached_screen_end), .clear_done(clear_done),
    .round_resetn(round_resetn), .clear_req(clear_req), .run(run), .level(level),
    .lives(lives), .score(score), .state(state), .game_over(game_over), .win(win)
  );

  always #5 clock = ~clock;

  // Behavioural model: game rules in plain integers; pauses as ticks remaining.
  int m_st = 0, m_level = 1, m_lives = SL, m_score = 0, m_left = 0;
  bit m_sq = 0, m_lose_pend = 0, m_win_pend = 0, m_rise;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_st = 0; m_level = 1; m_lives = SL; m_score = 0; m_sq = 0;
    end else begin
      m_rise = start && !m_sq;
      m_sq = start;
      case (m_st)
        0: if (m_rise) begin m_level = 1; m_lives = SL; m_score = 0; m_st = 1; end
        1: if (clear_done) m_st = 2;
        2: if (collided) begin
             m_lose_pend = (m_lives == 1);
             m_lives = m_lives - 1; m_left = PF; m_st = 3;
           end else if (reached_screen_end) begin
             m_score = (m_score < 255) ? m_score + 1 : 255;
             m_win_pend = (m_level == NL);
             if (!m_win_pend) begin
               m_level = m_level + 1;
`ifdef SNOOPY_BONUS_LIFE_EN
               if (m_lives < ML) m_lives = m_lives + 1;
`endif
             end
             m_left = PF; m_st = 4;
           end
        3, 4: if (m_st == 3 && m_lose_pend) m_st = 6;
              else if (m_st == 4 && m_win_pend) m_st = 5;
              else if (frame_tick) begin
                m_left = m_left - 1;
                if (m_left == 0) m_st = 1;
              end
        5, 6: if (m_rise) m_st = 0;
        default: m_st = 0;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("state", int'(state), m_st);
    chk("level", int'(level), m_level);
    chk("lives", int'(lives), m_lives);
    chk("score", int'(score), m_score);
    chk("run", int'(run), int'(m_st == 2));
    chk("clear_req", int'(clear_req), int'(m_st == 1));
    chk("round_resetn", int'(round_resetn), int'(m_st >= 2));
    chk("win", int'(win), int'(m_st == 5));
    chk("game_over", int'(game_over), int'(m_st == 6));
  end

  task automatic cyc(input logic s, input logic ft, input logic col, input logic rse, input logic cd);
    start = s; frame_tick = ft; collided = col; reached_screen_end = rse; clear_done = cd;
    @(negedge clock);
  endtask

  task automatic wait_st(input int code, input int budget, input bit ticks);
    int n = 0;
    while (m_st != code && n < budget) begin
      cyc(1'b0, ticks ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("wait_state", m_st, code);
  endtask

  task automatic pause_to_clear();
    int ticks = 0;
    int n = 0;
    logic ft;
    while (m_st != 1 && n < 400) begin
      ft = 1'($urandom_range(0, 1));
      if (ft) ticks++;
      cyc(1'b0, ft, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("pause_ticks", ticks, PF);
  endtask

  task automatic enter_play();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_st(2, 4, 1'b0);
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_run", int'(run), 0);
    chk("async_rrn", int'(round_resetn), 0);
    chk("async_lives", int'(lives), SL);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #22 reset = 1'b0;
    @(negedge clock);
    chk("rst_state", int'(state), 0);
    chk("rst_level", int'(level), 1);
    chk("rst_lives", int'(lives), 3);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("start_clear", int'(state), 1);
    chk("clear_rrn", int'(round_resetn), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    enter_play();
    chk("play_run", int'(run), 1);

    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("hit_state", int'(state), 3);
    chk("hit_lives", int'(lives), 2);
    chk("hit_run", int'(run), 0);
    pause_to_clear();
    enter_play();

    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lu_state", int'(state), 4);
    chk("lu_score", int'(score), 1);
    chk("lu_level", int'(level), 2);
    pause_to_clear();
    enter_play();

    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("both_state", int'(state), 3);
    chk("both_score", int'(score), 1);
    pause_to_clear();
    enter_play();

    for (int l = 2; l <= NL; l++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (l < NL) begin
        pause_to_clear();
        enter_play();
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("win_flag", int'(win), 1);
    chk("win_score", int'(score), 4);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("win_to_idle", int'(state), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    enter_play();
    for (int k = 0; k < SL; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (k < SL - 1) begin
        pause_to_clear();
        enter_play();
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lose_flag", int'(game_over), 1);

    for (int k = 0; k < 100; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("held_idle", int'(state), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("second_rise", int'(state), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    enter_play();
    async_reset_check();

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 499) == 0) async_reset_check();
      else cyc(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 11) == 0),
               1'($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
